regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 4 x 24-bit register file between two writeback sources: requester 0, the ALU result path, and requester 1, the load/immediate path. It applies round-robin arbitration and registers the winning write in a one-entry output stage. A stall input lets the core controller freeze register writes. It also exports a pending-write mask so read-side logic can detect read-after-write hazards.

## Interface
Parameters:
- DATA_W, 24, register data width
- ADDR_W, 2, register address width (2^ADDR_W registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- hold  in  1  stall from core controller; 1 blocks grants and freezes the output stage
- req0_valid  in  1  requester 0 has a write
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0
- write  out  1  register file write enable
- addr3  out  ADDR_W  register file write address
- data3  out  DATA_W  register file write data
- pending  out  2^ADDR_W  one-hot of addr3 when write=1, else 0

## Operation
- Handshake: a transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1. Requesters hold valid, addr and data stable until accepted.
- Grant logic:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - rr_last updates only on an accepted transfer. Reset value of rr_last = 1, so requester 0 wins the first tie.
- reqN_ready = grantN & ~hold & reset. Ready is combinational from valid, rr_last, hold and reset. Ready is never 1 for both requesters in the same cycle.
- Output stage:
  - Holds stage_valid, stage_addr and stage_data.
  - On an accepted transfer: loads the winner's addr/data and sets stage_valid=1.
  - On a cycle with ~hold and no transfer: stage_valid clears.
  - While hold=1: stage contents are unchanged.
- write = stage_valid & ~hold. addr3 = stage_addr. data3 = stage_data.
- When ~hold the stage always drains, so acceptance is never blocked by occupancy.
- Same destination from both requesters: writes commit in grant order, and the later write wins.
- reset=0 at any time, including mid-operation:
  - Clears stage_valid, stage_addr and stage_data to 0, and sets rr_last=1.
  - An in-flight write is discarded and never reaches the register file.
  - Both readies are 0 while reset=0.
- Reset values: write=0, addr3=0, data3=0, pending=0, req0_ready=0, req1_ready=0.

## Timing
- Acceptance at edge N → write=1 with the winner's addr/data during cycle N+1 → register file updated at edge N+1.
- The register file reads asynchronously, so the new value is readable from cycle N+2.
- pending is asserted exactly during the cycle write=1.
- Sustained throughput with hold=0: one write per cycle. Under continuous contention, grants alternate 0,1,0,1.
- hold rises while stage_valid=1: write drops to 0 that same cycle, and the stored write is issued in the first cycle after hold falls.

## Structure
- Package regfile_arb_pkg holds:
  - constants DATA_W=24 and ADDR_W=2;
  - typedef wr_req_t, a struct of addr [ADDR_W-1:0] and data [DATA_W-1:0];
  - typedef req_id_t (1 bit) for rr_last.
- Sub-module rr_arb2 is the 2-way round-robin grant: combinational grant from valids and rr_last, with rr_last update on accept.
- The top level instantiates rr_arb2 and the output-stage register, and drives the register file write port directly.

## Test plan
- Reset: reset=0 for 3 cycles with both valids high → write=0, readies=0, pending=0. First cycle after release → req0_ready=1.
- Single write: req0 addr=2, data=0x123456, hold=0 → req0_ready=1 in cycle N. In N+1: write=1, addr3=2, data3=0x123456, pending=4'b0100. Register 2 reads 0x123456 in N+2.
- Contention: both valid continuously, req0 addr=1 data=0xAAAAAA, req1 addr=3 data=0x555555 → readies alternate 0,1,0,1, and writes alternate addr3=1,3,1,3 one cycle later.
- Hold:
  - stage loaded with addr=0, data=0x000042, then hold=1 for 3 cycles → write=0 and readies=0 for those cycles;
  - hold=0 → write=1 with addr3=0, data3=0x000042, and grants resume in the same cycle.
- Reset mid-op: accept req1 addr=2, data=0xFFFFFF, then reset=0 on the next edge → write never asserts and register 2 is unchanged.
- Same-address tie: rr_last=0; req0 addr=1 data=0x000001 and req1 addr=1 data=0x000002 both valid → req1 is granted first, then req0. Final register 1 value = 0x000001.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds the default geometry, the write-request record and the requester id type.
package regfile_arb_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef logic req_id_t;

    // Requester 1 counts as granted last out of reset so requester 0 wins the first tie.
    localparam req_id_t RR_LAST_INIT = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant from the valids and the
// last-accepted requester, which is only updated on an accepted transfer.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic [1:0] accept,
    output logic [1:0] grant
);

    req_id_t rr_last_r;

    // Sole requester wins; on a tie the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last_r == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Track the requester whose transfer was accepted most recently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last_r <= RR_LAST_INIT;
        end else if (accept[0]) begin
            rr_last_r <= 1'b0;
        end else if (accept[1]) begin
            rr_last_r <= 1'b1;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port
// through a one-entry output stage that freezes while the core holds.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    output logic                     write,
    output logic [ADDR_W-1:0]        addr3,
    output logic [DATA_W-1:0]        data3,
    output logic [(1<<ADDR_W)-1:0]   pending
);

    localparam int NREG = 1 << ADDR_W;

    logic [1:0]        grant_s;
    logic [1:0]        accept_s;
    logic              stage_valid_r;
    logic [ADDR_W-1:0] stage_addr_r;
    logic [DATA_W-1:0] stage_data_r;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept_s),
        .grant  (grant_s)
    );

    assign req0_ready = grant_s[0] & ~hold & reset;
    assign req1_ready = grant_s[1] & ~hold & reset;
    assign accept_s   = {req1_valid & req1_ready, req0_valid & req0_ready};

    // Output stage: load the winner, drain when idle, freeze while held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_valid_r <= 1'b0;
            stage_addr_r  <= {ADDR_W{1'b0}};
            stage_data_r  <= {DATA_W{1'b0}};
        end else if (hold) begin
            stage_valid_r <= stage_valid_r;
            stage_addr_r  <= stage_addr_r;
            stage_data_r  <= stage_data_r;
        end else if (accept_s[0]) begin
            stage_valid_r <= 1'b1;
            stage_addr_r  <= req0_addr;
            stage_data_r  <= req0_data;
        end else if (accept_s[1]) begin
            stage_valid_r <= 1'b1;
            stage_addr_r  <= req1_addr;
            stage_data_r  <= req1_data;
        end else begin
            stage_valid_r <= 1'b0;
            stage_addr_r  <= stage_addr_r;
            stage_data_r  <= stage_data_r;
        end
    end

    // Write port drive; reset gating drops an in-flight write before the stage clears.
    always_comb begin
        write   = 1'b0;
        pending = {NREG{1'b0}};
        if (stage_valid_r && !hold && reset) begin
            write   = 1'b1;
            pending = {{(NREG-1){1'b0}}, 1'b1} << stage_addr_r;
        end else begin
            write   = 1'b0;
            pending = {NREG{1'b0}};
        end
    end

    assign addr3 = stage_addr_r;
    assign data3 = stage_data_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table for the documented scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset, hold;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]  req0_addr, req1_addr, addr3;
    logic [23:0] req0_data, req1_data, data3;
    logic        write;
    logic [3:0]  pending;
    logic [23:0] rf [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write(write), .addr3(addr3), .data3(data3), .pending(pending)
    );

    // register file fed by the arbiter's write port, read asynchronously
    always @(posedge clk) if (write) rf[addr3] <= data3;

    typedef struct {
        logic rst, hld, v0; logic [1:0] a0; logic [23:0] d0;
        logic v1; logic [1:0] a1; logic [23:0] d1;
        logic r0, r1, wr, chk_ad; logic [1:0] a3; logic [23:0] d3; logic [3:0] pend;
        logic chk_rf; logic [1:0] rf_idx; logic [23:0] rf_val;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, hld, v0, input logic [1:0] a0, input logic [23:0] d0,
                                input logic v1, input logic [1:0] a1, input logic [23:0] d1,
                                input logic r0, r1, wr, chk_ad, input logic [1:0] a3, input logic [23:0] d3,
                                input logic [3:0] pend, input logic chk_rf, input logic [1:0] rf_idx,
                                input logic [23:0] rf_val);
        vec_t v;
        v.rst = rst; v.hld = hld; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.wr = wr; v.chk_ad = chk_ad; v.a3 = a3; v.d3 = d3; v.pend = pend;
        v.chk_rf = chk_rf; v.rf_idx = rf_idx; v.rf_val = rf_val;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, hld, v0, input logic [1:0] a0, input logic [23:0] d0,
                         input logic v1, input logic [1:0] a1, input logic [23:0] d1);
        reset = rst; hold = hld;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    wr_req_t     q[$];
    req_id_t     last;
    logic [23:0] exp_rf [4];
    logic        rv [2];
    logic [1:0]  ra [2];
    logic [23:0] rd [2];
    logic        acc [2];

    initial begin
        // rst hld | v0 a0 d0 | v1 a1 d1 | r0 r1 wr chk a3 d3 pend | chk_rf idx val
        vq.push_back(mk(0,0, 1,2,24'h123456, 1,3,24'h555555, 0,0,0, 0,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(0,0, 1,2,24'h123456, 1,3,24'h555555, 0,0,0, 1,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(0,0, 1,2,24'h123456, 1,3,24'h555555, 0,0,0, 1,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,2,24'h123456, 1,3,24'h555555, 1,0,0, 1,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,2,24'h123456, 1,3,24'h555555, 0,1,1, 1,2,24'h123456, 4'b0100, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,1, 1,3,24'h555555, 4'b1000, 1,2,24'h123456));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,0, 0,0,24'h0,      4'b0000, 1,3,24'h555555));
        vq.push_back(mk(1,0, 1,1,24'hAAAAAA, 1,3,24'h555555, 1,0,0, 0,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,1,24'hAAAAAA, 1,3,24'h555555, 0,1,1, 1,1,24'hAAAAAA, 4'b0010, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,1,24'hAAAAAA, 1,3,24'h555555, 1,0,1, 1,3,24'h555555, 4'b1000, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,1,24'hAAAAAA, 1,3,24'h555555, 0,1,1, 1,1,24'hAAAAAA, 4'b0010, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,1, 1,3,24'h555555, 4'b1000, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,0,24'h000042, 0,0,24'h0,      1,0,0, 0,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,1, 0,0,24'h0,      1,2,24'h00ABCD, 0,0,0, 1,0,24'h000042, 4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,1, 0,0,24'h0,      1,2,24'h00ABCD, 0,0,0, 1,0,24'h000042, 4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,1, 0,0,24'h0,      1,2,24'h00ABCD, 0,0,0, 1,0,24'h000042, 4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      1,2,24'h00ABCD, 0,1,1, 1,0,24'h000042, 4'b0001, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,1, 1,2,24'h00ABCD, 4'b0100, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      1,2,24'hFFFFFF, 0,1,0, 0,0,24'h0,      4'b0000, 1,2,24'h00ABCD));
        vq.push_back(mk(0,0, 0,0,24'h0,      0,0,24'h0,      0,0,0, 0,0,24'h0,      4'b0000, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,0, 1,0,24'h0,      4'b0000, 1,2,24'h00ABCD));
        vq.push_back(mk(1,0, 1,1,24'h000009, 0,0,24'h0,      1,0,0, 0,0,24'h0,      4'b0000, 1,2,24'h00ABCD));
        vq.push_back(mk(1,0, 1,1,24'h000001, 1,1,24'h000002, 0,1,1, 1,1,24'h000009, 4'b0010, 0,0,24'h0));
        vq.push_back(mk(1,0, 1,1,24'h000001, 0,0,24'h0,      1,0,1, 1,1,24'h000002, 4'b0010, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,1, 1,1,24'h000001, 4'b0010, 0,0,24'h0));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,0, 0,0,24'h0,      4'b0000, 1,1,24'h000001));
        vq.push_back(mk(1,0, 0,0,24'h0,      0,0,24'h0,      0,0,0, 0,0,24'h0,      4'b0000, 1,0,24'h000042));

        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].hld, vq[k].v0, vq[k].a0, vq[k].d0, vq[k].v1, vq[k].a1, vq[k].d1);
            #4;
            check($sformatf("vec%0d req0_ready", k), req0_ready, vq[k].r0);
            check($sformatf("vec%0d req1_ready", k), req1_ready, vq[k].r1);
            check($sformatf("vec%0d write", k), write, vq[k].wr);
            check($sformatf("vec%0d pending", k), pending, vq[k].pend);
            if (vq[k].chk_ad) begin
                check($sformatf("vec%0d addr3", k), addr3, vq[k].a3);
                check($sformatf("vec%0d data3", k), data3, vq[k].d3);
            end
            if (vq[k].chk_rf)
                check($sformatf("vec%0d rf[%0d]", k, vq[k].rf_idx), rf[vq[k].rf_idx], vq[k].rf_val);
            @(posedge clk);
            #1;
        end

        // reference model state matching the register contents left by the table
        exp_rf[0] = 24'h000042; exp_rf[1] = 24'h000001; exp_rf[2] = 24'h00ABCD; exp_rf[3] = 24'h555555;
        last = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rv[n] = 1'b0; ra[n] = 2'd0; rd[n] = 24'd0; acc[n] = 1'b0;
        end

        for (int i = 0; i < 3000; i++) begin
            logic rst_b, hold_b, ew;
            logic [3:0] ep;
            int win;
            for (int n = 0; n < 2; n++) begin
                if (!rv[n] || acc[n]) begin
                    rv[n] = ($urandom_range(0, 2) != 0);
                    ra[n] = 2'($urandom_range(0, 3));
                    rd[n] = 24'($urandom);
                end
            end
            rst_b  = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
            hold_b = ($urandom_range(0, 4) == 0);
            drive(rst_b, hold_b, rv[0], ra[0], rd[0], rv[1], ra[1], rd[1]);

            win = -1;
            if (rst_b && !hold_b) begin
                if (rv[0] && rv[1]) win = (last == 1'b1) ? 0 : 1;
                else if (rv[0])     win = 0;
                else if (rv[1])     win = 1;
            end
            ew = rst_b && !hold_b && (q.size() > 0);
            ep = ew ? (4'b0001 << q[0].addr) : 4'b0000;

            #4;
            check($sformatf("rnd%0d req0_ready", i), req0_ready, (win == 0));
            check($sformatf("rnd%0d req1_ready", i), req1_ready, (win == 1));
            check($sformatf("rnd%0d write", i), write, ew);
            check($sformatf("rnd%0d pending", i), pending, ep);
            if (ew) begin
                check($sformatf("rnd%0d addr3", i), addr3, q[0].addr);
                check($sformatf("rnd%0d data3", i), data3, q[0].data);
            end

            if (!rst_b) begin
                q.delete();
                last = 1'b1;
            end else if (!hold_b) begin
                if (ew) begin
                    exp_rf[q[0].addr] = q[0].data;
                    void'(q.pop_front());
                end
                if (win >= 0) begin
                    q.push_back('{addr: ra[win], data: rd[win]});
                    last = (win == 1);
                end
            end
            acc[0] = (win == 0);
            acc[1] = (win == 1);
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 4; k++)
            check($sformatf("final rf[%0d]", k), rf[k], exp_rf[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
